lines_attack_manager: RTL and testbench

//  Parametrised successor to the lines-cleared counter. On each piece lock it

---
 rtl/lines_attack_manager_pkg.sv | 36 +++
 rtl/lines_attack_manager_attack_fifo.sv | 78 +++++++
 rtl/lines_attack_manager.sv | 148 ++++++++++++++
 tb/tb_lines_attack_manager.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lines_attack_manager_pkg.sv
// Shared game constants: playfield height, attack base table, combo bonus cap,
// and the row popcount helper used by line detection and attack scoring.
package lines_attack_manager_pkg;

   localparam int          PLAYFIELD_ROWS  = 20;
   localparam int          ROW_CNT_W       = $clog2(PLAYFIELD_ROWS + 1);
   localparam int unsigned MAX_CLEAR_ROWS  = 4;
   localparam int unsigned COMBO_BONUS_MAX = 4;

   localparam logic [3:0] ATK_SINGLE = 4'd0;
   localparam logic [3:0] ATK_DOUBLE = 4'd1;
   localparam logic [3:0] ATK_TRIPLE = 4'd2;
   localparam logic [3:0] ATK_TETRIS = 4'd4;

   function automatic logic [ROW_CNT_W-1:0] count_set_bits(input logic [PLAYFIELD_ROWS-1:0] rows);
      logic [ROW_CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < PLAYFIELD_ROWS; i++) begin
         cnt = cnt + ROW_CNT_W'(rows[i]);
      end
      return cnt;
   endfunction

   function automatic logic [3:0] attack_base(input logic [2:0] n);
      logic [3:0] base;
      case (n)
         3'd1:    base = ATK_SINGLE;
         3'd2:    base = ATK_DOUBLE;
         3'd3:    base = ATK_TRIPLE;
         3'd4:    base = ATK_TETRIS;
         default: base = 4'd0;
      endcase
      return base;
   endfunction

endpackage

// File: rtl/lines_attack_manager_attack_fifo.sv
// Attack queue: power-of-2 FIFO with valid/ready head. A push into a full
// queue with no pop is merged (saturating) into the tail entry instead.
module attack_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             overflow_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, tail_ptr;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q;
   logic             full, pop, merge, write;
   logic [WIDTH:0]   merge_sum;
   logic [WIDTH-1:0] merge_data;

   assign valid_o    = (count_q != '0);
   assign data_o     = mem_q[rd_ptr_q];
   assign overflow_o = overflow_q;
   assign full       = (count_q == (PTR_W+1)'(DEPTH));
   assign pop        = valid_o & ready_i;
   assign merge      = push_i & full & ~pop;
   assign write      = push_i & ~merge;
   assign tail_ptr   = wr_ptr_q - PTR_W'(1);
   assign merge_sum  = {1'b0, mem_q[tail_ptr]} + {1'b0, push_data_i};
   assign merge_data = merge_sum[WIDTH] ? '1 : merge_sum[WIDTH-1:0];

   always_comb begin
      count_d = count_q;
      case ({write, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (!flush_i) begin
         if (write) begin
            mem_q[wr_ptr_q] <= push_data_i;
         end else if (merge) begin
            mem_q[tail_ptr] <= merge_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (flush_i) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (write) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q    <= count_d;
         overflow_q <= merge;
      end
   end

endmodule

// File: rtl/lines_attack_manager.sv
// Per-lock line/attack scoring with combo and back-to-back tracking, feeding
// an attack FIFO. Optional LINES_TSPIN_EN macro enables T-spin scoring.
module lines_attack_manager
   import lines_attack_manager_pkg::*;
#(
   parameter int LINES_W     = 8,
   parameter int COMBO_W     = 4,
   parameter int SEND_W      = 4,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_l,
   input  logic                      game_start,
   input  logic                      piece_locked,
   input  logic [PLAYFIELD_ROWS-1:0] lines_full,
   input  logic                      tspin,
   output logic [LINES_W-1:0]        lines_cleared,
   output logic [LINES_W-1:0]        lines_sent,
   output logic [COMBO_W-1:0]        combo_count,
   output logic                      b2b_active,
   output logic                      send_valid,
   output logic [SEND_W-1:0]         send_lines,
   input  logic                      send_ready,
   output logic                      send_overflow
);

   localparam int unsigned SEND_MAX = (32'd1 << SEND_W) - 32'd1;

   logic [LINES_W-1:0]   lines_cleared_q, lines_cleared_d;
   logic [LINES_W-1:0]   lines_sent_q, lines_sent_d;
   logic [COMBO_W-1:0]   combo_count_q, combo_count_d;
   logic                 combo_active_q, combo_active_d;
   logic                 b2b_q, b2b_d;

   logic [ROW_CNT_W-1:0] rows_raw;
   logic [2:0]           n;
   logic                 clear;
   logic [COMBO_W:0]     combo_inc;
   logic [COMBO_W-1:0]   combo_next, combo_half;
   logic [3:0]           base;
   logic                 difficult, b2b_bonus;
   logic [2:0]           combo_bonus;
   logic [4:0]           atk_sum;
   logic [SEND_W-1:0]    atk;
   logic [LINES_W:0]     cleared_sum, sent_sum;
   logic                 push;

`ifndef LINES_TSPIN_EN
   logic tspin_unused;
   assign tspin_unused = tspin;
`endif

   assign rows_raw = count_set_bits(lines_full);
   assign n        = (rows_raw > ROW_CNT_W'(MAX_CLEAR_ROWS)) ? 3'(MAX_CLEAR_ROWS) : 3'(rows_raw);
   assign clear    = (n != 3'd0);

   always_comb begin
      combo_inc  = {1'b0, combo_count_q} + 1'b1;
      combo_next = combo_active_q ? (combo_inc[COMBO_W] ? '1 : combo_inc[COMBO_W-1:0]) : '0;
      base       = attack_base(n);
      difficult  = (n == 3'd4);
`ifdef LINES_TSPIN_EN
      if (tspin && clear) begin
         base      = {n, 1'b0};
         difficult = 1'b1;
      end
`endif
      b2b_bonus   = difficult & b2b_q;
      combo_half  = combo_next >> 1;
      combo_bonus = (32'(combo_half) > COMBO_BONUS_MAX) ? 3'(COMBO_BONUS_MAX) : 3'(combo_half);
      atk_sum     = 5'(base) + 5'(b2b_bonus) + 5'(combo_bonus);
      if (!clear) begin
         atk = '0;
      end else if (32'(atk_sum) > SEND_MAX) begin
         atk = SEND_W'(SEND_MAX);
      end else begin
         atk = SEND_W'(atk_sum);
      end
      cleared_sum = {1'b0, lines_cleared_q} + (LINES_W+1)'(n);
      sent_sum    = {1'b0, lines_sent_q} + (LINES_W+1)'(atk);
   end

   // game_start wins over a lock in the same cycle.
   always_comb begin
      lines_cleared_d = lines_cleared_q;
      lines_sent_d    = lines_sent_q;
      combo_count_d   = combo_count_q;
      combo_active_d  = combo_active_q;
      b2b_d           = b2b_q;
      if (game_start) begin
         lines_cleared_d = '0;
         lines_sent_d    = '0;
         combo_count_d   = '0;
         combo_active_d  = 1'b0;
         b2b_d           = 1'b0;
      end else if (piece_locked) begin
         if (clear) begin
            combo_count_d   = combo_next;
            combo_active_d  = 1'b1;
            b2b_d           = difficult;
            lines_cleared_d = cleared_sum[LINES_W] ? '1 : cleared_sum[LINES_W-1:0];
            lines_sent_d    = sent_sum[LINES_W] ? '1 : sent_sum[LINES_W-1:0];
         end else begin
            combo_count_d  = '0;
            combo_active_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         lines_cleared_q <= '0;
         lines_sent_q    <= '0;
         combo_count_q   <= '0;
         combo_active_q  <= 1'b0;
         b2b_q           <= 1'b0;
      end else begin
         lines_cleared_q <= lines_cleared_d;
         lines_sent_q    <= lines_sent_d;
         combo_count_q   <= combo_count_d;
         combo_active_q  <= combo_active_d;
         b2b_q           <= b2b_d;
      end
   end

   assign push = piece_locked & ~game_start & (atk != '0);

   attack_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (SEND_W)
   ) u_attack_fifo (
      .clk         (clk),
      .rst_l       (rst_l),
      .flush_i     (game_start),
      .push_i      (push),
      .push_data_i (atk),
      .ready_i     (send_ready),
      .valid_o     (send_valid),
      .data_o      (send_lines),
      .overflow_o  (send_overflow)
   );

   assign lines_cleared = lines_cleared_q;
   assign lines_sent    = lines_sent_q;
   assign combo_count   = combo_count_q;
   assign b2b_active    = b2b_q;

endmodule

// File: tb/tb_lines_attack_manager.sv
// Randomized and directed bench for lines_attack_manager against a queue-based
// scoring model; follows LINES_TSPIN_EN the same way the design build does.
module tb_lines_attack_manager;
   import lines_attack_manager_pkg::PLAYFIELD_ROWS;

   localparam int LW = 8;
   localparam int CW = 4;
   localparam int SW = 4;
   localparam int QD = 4;
   localparam int LINES_MAX = 255;
   localparam int COMBO_MAX = 15;
   localparam int SEND_MAX  = 15;

   logic                      clk = 1'b0;
   logic                      rst_l;
   logic                      game_start;
   logic                      piece_locked;
   logic [PLAYFIELD_ROWS-1:0] lines_full;
   logic                      tspin;
   logic [LW-1:0]             lines_cleared;
   logic [LW-1:0]             lines_sent;
   logic [CW-1:0]             combo_count;
   logic                      b2b_active;
   logic                      send_valid;
   logic [SW-1:0]             send_lines;
   logic                      send_ready;
   logic                      send_overflow;

   always #5 clk = ~clk;

   lines_attack_manager #(
      .LINES_W     (LW),
      .COMBO_W     (CW),
      .SEND_W      (SW),
      .QUEUE_DEPTH (QD)
   ) dut (
      .clk           (clk),
      .rst_l         (rst_l),
      .game_start    (game_start),
      .piece_locked  (piece_locked),
      .lines_full    (lines_full),
      .tspin         (tspin),
      .lines_cleared (lines_cleared),
      .lines_sent    (lines_sent),
      .combo_count   (combo_count),
      .b2b_active    (b2b_active),
      .send_valid    (send_valid),
      .send_lines    (send_lines),
      .send_ready    (send_ready),
      .send_overflow (send_overflow)
   );

   int vectors     = 0;
   int miscompares = 0;

   int m_cleared, m_sent, m_combo;
   bit m_combo_act, m_b2b, m_ovf;
   int m_q[$];

   localparam logic [PLAYFIELD_ROWS-1:0] ROWS4 = PLAYFIELD_ROWS'(20'h0000F);
   localparam logic [PLAYFIELD_ROWS-1:0] ROWS2 = PLAYFIELD_ROWS'(20'h00300);
   localparam logic [PLAYFIELD_ROWS-1:0] ROWS1 = PLAYFIELD_ROWS'(20'h01000);
   localparam logic [PLAYFIELD_ROWS-1:0] ROWS0 = '0;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void model_clear();
      m_cleared = 0; m_sent = 0; m_combo = 0;
      m_combo_act = 0; m_b2b = 0; m_ovf = 0;
      m_q.delete();
   endfunction

   // Scoring rules stated directly: table lookup plus bonuses, then queue.
   function automatic void model_update();
      int  n, base, atk;
      bit  diff, pop, full_before;
      m_ovf = 0;
      if (game_start) begin
         model_clear();
         return;
      end
      atk = 0;
      pop = (m_q.size() > 0) && send_ready;
      full_before = (m_q.size() == QD);
      if (piece_locked) begin
         n = imin($countones(lines_full), 4);
         if (n == 0) begin
            m_combo = 0;
            m_combo_act = 0;
         end else begin
            m_combo = m_combo_act ? imin(m_combo + 1, COMBO_MAX) : 0;
            m_combo_act = 1;
            case (n)
               1: base = 0;
               2: base = 1;
               3: base = 2;
               default: base = 4;
            endcase
            diff = (n == 4);
`ifdef LINES_TSPIN_EN
            if (tspin) begin
               base = 2 * n;
               diff = 1;
            end
`endif
            atk = base + ((diff && m_b2b) ? 1 : 0) + imin(m_combo / 2, 4);
            atk = imin(atk, SEND_MAX);
            m_b2b = diff;
            m_cleared = imin(m_cleared + n, LINES_MAX);
            m_sent = imin(m_sent + atk, LINES_MAX);
         end
      end
      if (pop) void'(m_q.pop_front());
      if (atk > 0) begin
         if (full_before && !pop) begin
            m_q[m_q.size()-1] = imin(m_q[m_q.size()-1] + atk, SEND_MAX);
            m_ovf = 1;
         end else begin
            m_q.push_back(atk);
         end
      end
   endfunction

   function automatic logic [26:0] exp_vec();
      logic [3:0] head;
      head = (m_q.size() > 0) ? 4'(m_q[0]) : 4'd0;
      return {8'(m_cleared), 8'(m_sent), 4'(m_combo), m_b2b, m_q.size() > 0, head, m_ovf};
   endfunction

   function automatic logic [26:0] obs_vec();
      return {lines_cleared, lines_sent, combo_count, b2b_active, send_valid,
              (send_valid ? send_lines : 4'd0), send_overflow};
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic lk, input logic [PLAYFIELD_ROWS-1:0] lf,
                       input logic ts, input logic rdy, input logic gs);
      piece_locked = lk;
      lines_full   = lf;
      tspin        = ts;
      send_ready   = rdy;
      game_start   = gs;
      model_update();
      @(posedge clk);
      @(negedge clk);
      piece_locked = 1'b0;
      game_start   = 1'b0;
   endtask

   task automatic test_reset();
      rst_l = 1'b0; game_start = 0; piece_locked = 0; lines_full = '0;
      tspin = 0; send_ready = 0;
      model_clear();
      #12;
      vectors++;
      if (obs_vec() !== 27'd0) begin
         miscompares++;
         $display("FAIL reset: got %h expected %h", obs_vec(), 27'd0);
      end
      @(negedge clk);
      rst_l = 1'b1;
   endtask

   task automatic test_tetris();
      step(1, ROWS4, 0, 1, 0);
      vectors++;
      if (obs_vec() !== {8'd4, 8'd4, 4'd0, 1'b1, 1'b1, 4'd4, 1'b0}) begin
         miscompares++;
         $display("FAIL tetris_first: got %h expected %h", obs_vec(), {8'd4, 8'd4, 4'd0, 1'b1, 1'b1, 4'd4, 1'b0});
      end
      step(1, ROWS4, 0, 1, 0);
      vectors++;
      if (obs_vec() !== {8'd8, 8'd9, 4'd1, 1'b1, 1'b1, 4'd5, 1'b0}) begin
         miscompares++;
         $display("FAIL tetris_b2b: got %h expected %h", obs_vec(), {8'd8, 8'd9, 4'd1, 1'b1, 1'b1, 4'd5, 1'b0});
      end
   endtask

   task automatic test_singles();
      step(1, ROWS0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, ROWS1, 0, 1, 0);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL singles[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
      vectors++;
      if ({lines_sent, combo_count, b2b_active} !== {8'd11, 4'd3, 1'b0}) begin
         miscompares++;
         $display("FAIL singles_totals: got sent=%0d combo=%0d b2b=%0d expected 11 3 0",
                  lines_sent, combo_count, b2b_active);
      end
   endtask

   task automatic test_overflow();
      step(0, ROWS0, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         step(1, ROWS4, 0, 0, 0);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL overflow_fill[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         end
         if (i == 4) begin
            vectors++;
            if (send_overflow !== 1'b1) begin
               miscompares++;
               $display("FAIL overflow_pulse: got %0b expected 1", send_overflow);
            end
         end
      end
      step(0, ROWS0, 0, 0, 0);
      vectors++;
      if (send_overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL overflow_clear: got %0b expected 0", send_overflow);
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 3) begin
            vectors++;
            if (send_lines !== 4'd15) begin
               miscompares++;
               $display("FAIL overflow_sat_tail: got %0d expected 15", send_lines);
            end
         end
         step(0, ROWS0, 0, 1, 0);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL overflow_drain[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_game_start_lock();
      step(1, ROWS4, 0, 0, 0);
      step(1, ROWS4, 0, 0, 1);
      vectors++;
      if (obs_vec() !== 27'd0) begin
         miscompares++;
         $display("FAIL start_beats_lock: got %h expected %h", obs_vec(), 27'd0);
      end
   endtask

   task automatic test_tspin();
      logic [4:0] want;
`ifdef LINES_TSPIN_EN
      want = {1'b1, 4'd4};
`else
      want = {1'b0, 4'd1};
`endif
      step(0, ROWS0, 0, 1, 1);
      step(1, ROWS2, 1, 1, 0);
      vectors++;
      if ({b2b_active, send_lines} !== want) begin
         miscompares++;
         $display("FAIL tspin_double: got b2b=%0b atk=%0d expected b2b=%0b atk=%0d",
                  b2b_active, send_lines, want[4], want[3:0]);
      end
      step(1, ROWS0, 1, 1, 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
         miscompares++;
         $display("FAIL tspin_noclear: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      logic [PLAYFIELD_ROWS-1:0] rows;
      int k;
      step(0, ROWS0, 0, 1, 1);
      for (int i = 0; i < 400; i++) begin
         rows = '0;
         k = $urandom_range(0, 5);
         for (int j = 0; j < k; j++) rows[$urandom_range(0, PLAYFIELD_ROWS-1)] = 1'b1;
         step(1'($urandom_range(0, 1)), rows, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 60) == 0));
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_async_reset();
      step(0, ROWS0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, ROWS4, 0, 0, 0);
      step(0, ROWS0, 0, 1, 0);
      #2 rst_l = 1'b0;
      #1;
      model_clear();
      vectors++;
      if (obs_vec() !== 27'd0) begin
         miscompares++;
         $display("FAIL async_reset: got %h expected %h", obs_vec(), 27'd0);
      end
      @(negedge clk);
      rst_l = 1'b1;
      step(1, ROWS4, 0, 0, 0);
      vectors++;
      if (obs_vec() !== {8'd4, 8'd4, 4'd0, 1'b1, 1'b1, 4'd4, 1'b0}) begin
         miscompares++;
         $display("FAIL after_async_reset: got %h expected %h", obs_vec(), {8'd4, 8'd4, 4'd0, 1'b1, 1'b1, 4'd4, 1'b0});
      end
      step(0, ROWS0, 0, 1, 0);
      vectors++;
      if (send_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_dropped_queue: got valid=%0b expected 0", send_valid);
      end
   endtask

   initial begin
      test_reset();
      test_tetris();
      test_singles();
      test_overflow();
      test_game_start_lock();
      test_tspin();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
